int_issue_queue: RTL and testbench

Integer reservation station that sits in front of the integer execution unit.
- Accepts dispatched integer/branch ops whose source operands may still be pending on a tag.
- Snoops the common data bus (cdb_bus) to capture results by tag.
- Issues the oldest fully-ready op to the integer execution unit as a registered one-cycle issue pulse carrying Opcode/Funct3/Funct7/RS1/RS2/RD_Tag.

---
 rtl/int_issue_queue.sv | 169 ++++++++++++++++
 tb/tb_int_issue_queue.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_issue_queue.sv
// Integer reservation station: collapsing age-ordered queue with CDB wakeup
// and a registered one-cycle issue pulse for the oldest fully-ready op.
package int_iq_pkg;
  typedef struct packed {
    logic [31:0] cdb_data;
    logic [5:0]  cdb_tag;
    logic        cdb_valid;
    logic        cdb_branch;
    logic        cdb_branch_taken;
  } cdb_bus;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  tag;
    logic        rdy;
  } iq_src_t;

  typedef struct packed {
    logic       valid;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [5:0] rd_tag;
    iq_src_t    rs1;
    iq_src_t    rs2;
  } iq_entry_t;
endpackage

module int_issue_queue
  import int_iq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             dispatch_valid,
  input  logic [6:0]       dispatch_opcode,
  input  logic [2:0]       dispatch_funct3,
  input  logic [6:0]       dispatch_funct7,
  input  logic [31:0]      dispatch_rs1_data,
  input  logic [5:0]       dispatch_rs1_tag,
  input  logic             dispatch_rs1_rdy,
  input  logic [31:0]      dispatch_rs2_data,
  input  logic [5:0]       dispatch_rs2_tag,
  input  logic             dispatch_rs2_rdy,
  input  logic [5:0]       dispatch_rd_tag,
  input  cdb_bus           cdb,
  output logic             iq_full,
  output logic [CNT_W-1:0] iq_count,
  output logic             issue_int,
  output logic [6:0]       issue_opcode,
  output logic [2:0]       issue_funct3,
  output logic [6:0]       issue_funct7,
  output logic [31:0]      issue_rs1,
  output logic [31:0]      issue_rs2,
  output logic [5:0]       issue_rd_tag
);

  iq_entry_t        ent_q [DEPTH];
  iq_entry_t        ent_d [DEPTH];
  iq_entry_t        ent_w [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             iss_vld_q;
  iq_entry_t        iss_q;

  logic             sel_vld;
  int               sel_pos;
  iq_entry_t        sel_ent;
  logic             disp_ok;
  int               wr_pos;
  iq_entry_t        disp_ent;

  // Branch outcome fields are consumed elsewhere in the core.
  logic unused_cdb;
  assign unused_cdb = cdb.cdb_branch ^ cdb.cdb_branch_taken;

  function automatic iq_src_t wake(iq_src_t s, cdb_bus c);
    wake = s;
    if (!s.rdy && c.cdb_valid && (s.tag == c.cdb_tag)) begin
      wake.data = c.cdb_data;
      wake.rdy  = 1'b1;
    end
  endfunction

  assign iq_full = (cnt_q == CNT_W'(DEPTH));
  assign disp_ok = dispatch_valid && !iq_full && !flush;

  // Oldest ready entry, judged on start-of-cycle state only.
  always_comb begin
    sel_vld = 1'b0;
    sel_pos = 0;
    sel_ent = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].valid && ent_q[i].rs1.rdy && ent_q[i].rs2.rdy) begin
        sel_vld = 1'b1;
        sel_pos = i;
        sel_ent = ent_q[i];
      end
    end
  end

  always_comb begin
    disp_ent        = '0;
    disp_ent.valid  = 1'b1;
    disp_ent.opcode = dispatch_opcode;
    disp_ent.funct3 = dispatch_funct3;
    disp_ent.funct7 = dispatch_funct7;
    disp_ent.rd_tag = dispatch_rd_tag;
    disp_ent.rs1    = wake({dispatch_rs1_data, dispatch_rs1_tag, dispatch_rs1_rdy}, cdb);
    disp_ent.rs2    = wake({dispatch_rs2_data, dispatch_rs2_tag, dispatch_rs2_rdy}, cdb);
  end

  assign wr_pos = int'(cnt_q) - int'(sel_vld);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_w[i] = ent_q[i];
      if (ent_q[i].valid) begin
        ent_w[i].rs1 = wake(ent_q[i].rs1, cdb);
        ent_w[i].rs2 = wake(ent_q[i].rs2, cdb);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_w[i];
      if (sel_vld && i >= sel_pos) ent_d[i] = '0;
    end
    // Collapse everything above the issued slot down by one.
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (sel_vld && i >= sel_pos) ent_d[i] = ent_w[i+1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (disp_ok && i == wr_pos) ent_d[i] = disp_ent;
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
    end
  end

  always_comb begin
    if (flush) cnt_d = '0;
    else       cnt_d = cnt_q + CNT_W'(disp_ok) - CNT_W'(sel_vld);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      cnt_q     <= '0;
      iss_vld_q <= 1'b0;
      iss_q     <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      cnt_q     <= cnt_d;
      iss_vld_q <= sel_vld && !flush;
      iss_q     <= (sel_vld && !flush) ? sel_ent : '0;
    end
  end

  assign iq_count     = cnt_q;
  assign issue_int    = iss_vld_q;
  assign issue_opcode = iss_q.opcode;
  assign issue_funct3 = iss_q.funct3;
  assign issue_funct7 = iss_q.funct7;
  assign issue_rs1    = iss_q.rs1.data;
  assign issue_rs2    = iss_q.rs2.data;
  assign issue_rd_tag = iss_q.rd_tag;

endmodule

// File: tb/tb_int_issue_queue.sv
// Bench for int_issue_queue: table of ready ops plus hand-built sequences;
// expected issues go to a scoreboard queue and are checked on each pulse.
module tb_int_issue_queue;
  import int_iq_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush;
  logic             dispatch_valid;
  logic [6:0]       dispatch_opcode;
  logic [2:0]       dispatch_funct3;
  logic [6:0]       dispatch_funct7;
  logic [31:0]      dispatch_rs1_data;
  logic [5:0]       dispatch_rs1_tag;
  logic             dispatch_rs1_rdy;
  logic [31:0]      dispatch_rs2_data;
  logic [5:0]       dispatch_rs2_tag;
  logic             dispatch_rs2_rdy;
  logic [5:0]       dispatch_rd_tag;
  cdb_bus           cdb;
  logic             iq_full;
  logic [CNT_W-1:0] iq_count;
  logic             issue_int;
  logic [6:0]       issue_opcode;
  logic [2:0]       issue_funct3;
  logic [6:0]       issue_funct7;
  logic [31:0]      issue_rs1;
  logic [31:0]      issue_rs2;
  logic [5:0]       issue_rd_tag;

  int_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_opcode(dispatch_opcode),
    .dispatch_funct3(dispatch_funct3), .dispatch_funct7(dispatch_funct7),
    .dispatch_rs1_data(dispatch_rs1_data), .dispatch_rs1_tag(dispatch_rs1_tag),
    .dispatch_rs1_rdy(dispatch_rs1_rdy), .dispatch_rs2_data(dispatch_rs2_data),
    .dispatch_rs2_tag(dispatch_rs2_tag), .dispatch_rs2_rdy(dispatch_rs2_rdy),
    .dispatch_rd_tag(dispatch_rd_tag), .cdb(cdb),
    .iq_full(iq_full), .iq_count(iq_count), .issue_int(issue_int),
    .issue_opcode(issue_opcode), .issue_funct3(issue_funct3),
    .issue_funct7(issue_funct7), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd_tag(issue_rd_tag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  rd;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  rd;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [5:0]  exp_rd;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle();
    dispatch_valid = 1'b0; dispatch_opcode = '0; dispatch_funct3 = '0;
    dispatch_funct7 = '0; dispatch_rs1_data = '0; dispatch_rs1_tag = '0;
    dispatch_rs1_rdy = 1'b0; dispatch_rs2_data = '0; dispatch_rs2_tag = '0;
    dispatch_rs2_rdy = 1'b0; dispatch_rd_tag = '0; cdb = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic disp(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [5:0] ta, input logic ra,
                      input logic [31:0] b, input logic [5:0] tb, input logic rb,
                      input logic [5:0] rd);
    dispatch_valid = 1'b1; dispatch_opcode = op; dispatch_funct3 = f3;
    dispatch_funct7 = f7; dispatch_rs1_data = a; dispatch_rs1_tag = ta;
    dispatch_rs1_rdy = ra; dispatch_rs2_data = b; dispatch_rs2_tag = tb;
    dispatch_rs2_rdy = rb; dispatch_rd_tag = rd;
  endtask

  task automatic push(input int due, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                      input logic [5:0] rd);
    exp_t e;
    e.due = due; e.op = op; e.f3 = f3; e.f7 = f7; e.a = a; e.b = b; e.rd = rd;
    exp_q.push_back(e);
  endtask

  task automatic cdb_set(input logic [5:0] tag, input logic [31:0] data);
    cdb = '0;
    cdb.cdb_valid = 1'b1;
    cdb.cdb_tag   = tag;
    cdb.cdb_data  = data;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      tick();
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // Scoreboard side: every issue pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (issue_int === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_issue: rd_tag=%0d cycle=%0d", issue_rd_tag, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("issue_cycle", cyc, e.due);
        chk("issue_opcode", {25'd0, issue_opcode}, {25'd0, e.op});
        chk("issue_funct3", {29'd0, issue_funct3}, {29'd0, e.f3});
        chk("issue_funct7", {25'd0, issue_funct7}, {25'd0, e.f7});
        chk("issue_rs1", issue_rs1, e.a);
        chk("issue_rs2", issue_rs2, e.b);
        chk("issue_rd_tag", {26'd0, issue_rd_tag}, {26'd0, e.rd});
      end
    end else begin
      chk("idle_fields_zero",
          {31'd0, |{issue_opcode, issue_funct3, issue_funct7, issue_rs1, issue_rs2, issue_rd_tag}},
          32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit hit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  localparam logic [6:0] OP_R = 7'b0110011;

  initial begin
    int w;
    vt[0] = '{OP_R, 3'b000, 7'b0000000, 32'd5, 32'd7, 6'd3, 32'd5, 32'd7, 6'd3};
    vt[1] = '{OP_R, 3'b000, 7'b0100000, 32'hFFFF_FFFF, 32'd1, 6'd63, 32'hFFFF_FFFF, 32'd1, 6'd63};
    vt[2] = '{7'b1100011, 3'b000, 7'd0, 32'h8000_0000, 32'h8000_0000, 6'd0, 32'h8000_0000, 32'h8000_0000, 6'd0};
    vt[3] = '{7'b0010011, 3'b100, 7'd0, 32'h1234_5678, 32'd0, 6'd17, 32'h1234_5678, 32'd0, 6'd17};

    idle();
    tick(); tick();
    chk("reset_count", {29'd0, iq_count}, 0);
    chk("reset_full", {31'd0, iq_full}, 0);
    chk("reset_issue", {31'd0, issue_int}, 0);
    rst = 1'b0;

    // Ready ops: issue two cycles after dispatch, count 1 then 0.
    for (int k = 0; k < 4; k++) begin
      disp(vt[k].op, vt[k].f3, vt[k].f7, vt[k].a, 6'd0, 1'b1, vt[k].b, 6'd0, 1'b1, vt[k].rd);
      push(cyc + 2, vt[k].op, vt[k].f3, vt[k].f7, vt[k].exp_a, vt[k].exp_b, vt[k].exp_rd);
      tick();
      chk("ready_count1", {29'd0, iq_count}, 1);
      tick();
      chk("ready_count0", {29'd0, iq_count}, 0);
    end
    drain(8);

    // Wakeup; the ready rs2 shares tag 9 and must keep its value.
    disp(OP_R, 3'b000, 7'd0, 32'hBAD, 6'd9, 1'b0, 32'd1, 6'd9, 1'b1, 6'd20);
    tick(); tick();
    cdb_set(6'd8, 32'h555);
    tick();
    chk("wake_wait_count", {29'd0, iq_count}, 1);
    cdb_set(6'd9, 32'h100);
    push(cyc + 2, OP_R, 3'b000, 7'd0, 32'h100, 32'd1, 6'd20);
    tick(); tick();
    chk("wake_count0", {29'd0, iq_count}, 0);
    drain(6);

    // Same-cycle CDB bypass into a dispatched source.
    cdb_set(6'd12, 32'hDEAD);
    disp(OP_R, 3'b111, 7'd0, 32'd3, 6'd0, 1'b1, 32'd0, 6'd12, 1'b0, 6'd21);
    push(cyc + 2, OP_R, 3'b111, 7'd0, 32'd3, 32'hDEAD, 6'd21);
    drain(6);

    // Fill, full behaviour, age order and collapse.
    disp(OP_R, 3'b000, 7'd0, 32'd0, 6'd4, 1'b0, 32'hA2, 6'd0, 1'b1, 6'd10); tick();
    disp(OP_R, 3'b000, 7'd0, 32'd0, 6'd5, 1'b0, 32'hB2, 6'd0, 1'b1, 6'd11); tick();
    disp(OP_R, 3'b000, 7'd0, 32'd0, 6'd5, 1'b0, 32'hC2, 6'd0, 1'b1, 6'd12); tick();
    disp(OP_R, 3'b000, 7'd0, 32'd0, 6'd5, 1'b0, 32'hD2, 6'd0, 1'b1, 6'd13); tick();
    chk("full_count", {29'd0, iq_count}, 4);
    chk("full_flag", {31'd0, iq_full}, 1);
    disp(OP_R, 3'b000, 7'd0, 32'd1, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 6'd14);
    tick();
    chk("full_drop_count", {29'd0, iq_count}, 4);
    chk("full_drop_flag", {31'd0, iq_full}, 1);
    w = cyc;
    cdb_set(6'd5, 32'h50);
    push(w + 2, OP_R, 3'b000, 7'd0, 32'h50, 32'hB2, 6'd11);
    push(w + 3, OP_R, 3'b000, 7'd0, 32'h50, 32'hC2, 6'd12);
    push(w + 4, OP_R, 3'b000, 7'd0, 32'h50, 32'hD2, 6'd13);
    tick();
    disp(OP_R, 3'b000, 7'd0, 32'd1, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 6'd15);
    tick();
    chk("full_issue_no_free_count", {29'd0, iq_count}, 3);
    chk("full_issue_no_free_flag", {31'd0, iq_full}, 0);
    tick();
    chk("collapse_count2", {29'd0, iq_count}, 2);
    tick();
    chk("collapse_count1", {29'd0, iq_count}, 1);
    cdb_set(6'd4, 32'h40);
    push(cyc + 2, OP_R, 3'b000, 7'd0, 32'h40, 32'hA2, 6'd10);
    drain(8);
    chk("collapse_empty", {29'd0, iq_count}, 0);

    // Flush with an issue pending and a same-cycle dispatch.
    disp(OP_R, 3'b000, 7'd0, 32'd0, 6'd30, 1'b0, 32'd2, 6'd0, 1'b1, 6'd30); tick();
    disp(OP_R, 3'b000, 7'd0, 32'd0, 6'd30, 1'b0, 32'd2, 6'd0, 1'b1, 6'd31); tick();
    disp(OP_R, 3'b000, 7'd0, 32'd9, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 6'd22); tick();
    chk("flush_pre_count", {29'd0, iq_count}, 3);
    flush = 1'b1;
    disp(OP_R, 3'b000, 7'd0, 32'd9, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 6'd23);
    tick();
    chk("flush_count", {29'd0, iq_count}, 0);
    chk("flush_issue", {31'd0, issue_int}, 0);
    chk("flush_full", {31'd0, iq_full}, 0);
    cdb_set(6'd30, 32'h77);
    tick(); tick(); tick();
    chk("flush_stays_empty", {29'd0, iq_count}, 0);

    // Reset mid-operation with an issue pending.
    disp(OP_R, 3'b000, 7'd0, 32'd0, 6'd40, 1'b0, 32'd2, 6'd0, 1'b1, 6'd40); tick();
    disp(OP_R, 3'b000, 7'd0, 32'd8, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 6'd25); tick();
    chk("rst_pre_count", {29'd0, iq_count}, 2);
    rst = 1'b1;
    tick();
    chk("rst_count", {29'd0, iq_count}, 0);
    chk("rst_issue", {31'd0, issue_int}, 0);
    chk("rst_full", {31'd0, iq_full}, 0);
    rst = 1'b0;
    cdb_set(6'd40, 32'h99);
    tick(); tick();
    chk("rst_stays_empty", {29'd0, iq_count}, 0);
    disp(OP_R, 3'b001, 7'd0, 32'h11, 6'd0, 1'b1, 32'd4, 6'd0, 1'b1, 6'd26);
    push(cyc + 2, OP_R, 3'b001, 7'd0, 32'h11, 32'd4, 6'd26);
    drain(6);

    tick(); tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
